// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and sign/magnitude helpers for the multiplier operand stage
package mul_pkg;

    localparam int MUL_MAXW = 64;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } op_state_e;

    // Operates on a zero-extended w-bit operand; returns {mag, sign} with sign in bit 0
    // so callers can truncate to (w+1) bits with a single cast.
    function automatic logic [MUL_MAXW:0] sm_mag(input logic [MUL_MAXW-1:0] x,
                                                 input int unsigned w);
        logic [MUL_MAXW-1:0] mask;
        logic [MUL_MAXW-1:0] mag;
        logic                sign;
        mask = {MUL_MAXW{1'b1}} >> (MUL_MAXW - w);
        sign = |(x & mask & ~(mask >> 1));
        mag  = sign ? ((~x + MUL_MAXW'(1)) & mask) : x;
        return {mag, sign};
    endfunction

    // map[k] = OR of all magnitude bits above k; zero-extension keeps the top bit 0.
    function automatic logic [MUL_MAXW-1:0] high_map(input logic [MUL_MAXW-1:0] mag);
        logic [MUL_MAXW-1:0] m;
        logic                seen;
        m    = '0;
        seen = 1'b0;
        for (int k = MUL_MAXW - 1; k >= 0; k--) begin
            m[k] = seen;
            seen = seen | mag[k];
        end
        return m;
    endfunction

endpackage

// File: rtl/mul_sm_conv.sv
// rtl/mul_sm_conv.sv - combinational two's-complement to sign+magnitude converter
module mul_sm_conv
    import mul_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] data_i,
    output logic [BITS-1:0] mag_o,
    output logic            sign_o
);

    assign {mag_o, sign_o} = (BITS + 1)'(sm_mag(MUL_MAXW'(data_i), BITS));

endmodule

// File: rtl/mul_operand_stage.sv
// rtl/mul_operand_stage.sv - collects A then B, registers sign/magnitude pair and A high-bit map
// Optional zero_o output enabled by MUL_OPSTAGE_ZERO_FLAG_EN.
module mul_operand_stage
    import mul_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] A_mag,
    output logic [BITS-1:0] B_mag,
    output logic [BITS-1:0] a_map,
    output logic            Sign_a,
    output logic            Sign_b
`ifdef MUL_OPSTAGE_ZERO_FLAG_EN
    ,
    output logic            zero_o
`endif
);

    op_state_e       state_q, state_d;
    logic [BITS-1:0] a_mag_q, b_mag_q, a_map_q;
    logic            sign_a_q, sign_b_q;
    logic [BITS-1:0] conv_mag;
    logic            conv_sign;
    logic            accept, cap_a, cap_b;

    mul_sm_conv #(.BITS(BITS)) u_conv (
        .data_i (in_data),
        .mag_o  (conv_mag),
        .sign_o (conv_sign)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b1;
        if (state_q == S_OUT) begin
            in_ready = out_ready;
        end
        if (flush) begin
            in_ready = 1'b0;
        end
        accept = in_valid & in_ready;
        cap_a  = accept & (state_q != S_B);
        cap_b  = accept & (state_q == S_B);

        case (state_q)
            S_A:     if (accept) state_d = S_B;
            S_B:     if (accept) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = accept ? S_B : S_A;
            default: state_d = S_A;
        endcase
        if (flush) begin
            state_d = S_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            a_map_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_a) begin
                a_mag_q  <= conv_mag;
                sign_a_q <= conv_sign;
                a_map_q  <= BITS'(high_map(MUL_MAXW'(conv_mag)));
            end
            if (cap_b) begin
                b_mag_q  <= conv_mag;
                sign_b_q <= conv_sign;
            end
        end
    end

`ifdef MUL_OPSTAGE_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (cap_b) begin
            zero_q <= (a_mag_q == '0) | (conv_mag == '0);
        end
    end

    assign zero_o = zero_q;
`endif

    assign out_valid = (state_q == S_OUT);
    assign A_mag     = a_mag_q;
    assign B_mag     = b_mag_q;
    assign a_map     = a_map_q;
    assign Sign_a    = sign_a_q;
    assign Sign_b    = sign_b_q;

endmodule

// File: tb/tb_mul_operand_stage.sv
// tb/tb_mul_operand_stage.sv - table-driven and sequence checks for mul_operand_stage
module tb_mul_operand_stage;

    localparam int BITS = 16;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, out_ready;
    logic            in_ready, out_valid;
    logic [BITS-1:0] in_data;
    logic [BITS-1:0] A_mag, B_mag, a_map;
    logic            Sign_a, Sign_b;
`ifdef MUL_OPSTAGE_ZERO_FLAG_EN
    logic            zero_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_operand_stage #(.BITS(BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_mag     (A_mag),
        .B_mag     (B_mag),
        .a_map     (a_map),
        .Sign_a    (Sign_a),
        .Sign_b    (Sign_b)
`ifdef MUL_OPSTAGE_ZERO_FLAG_EN
        ,
        .zero_o    (zero_o)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] a_mag;
        logic [15:0] b_mag;
        logic        sa;
        logic        sb;
        logic [15:0] map;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic check_pair(input string tag, input logic [15:0] am, input logic [15:0] bm,
                              input logic sa, input logic sb, input logic [15:0] mp);
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_amag"},  32'(A_mag),     32'(am));
        check({tag, "_bmag"},  32'(B_mag),     32'(bm));
        check({tag, "_sa"},    32'(Sign_a),    32'(sa));
        check({tag, "_sb"},    32'(Sign_b),    32'(sb));
        check({tag, "_map"},   32'(a_map),     32'(mp));
    endtask

    initial begin
        vecs[0] = '{16'hFFFD, 16'h0005, 16'h0003, 16'h0005, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[1] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1'b0};
        vecs[2] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[4] = '{16'h0100, 16'hFF00, 16'h0100, 16'h0100, 1'b0, 1'b1, 16'h00FF, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h8001, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h3FFF, 1'b0};
        vecs[6] = '{16'hC000, 16'h0003, 16'h4000, 16'h0003, 1'b1, 1'b0, 16'h3FFF, 1'b0};
        vecs[7] = '{16'h0000, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_ready", 32'(in_ready),  32'(1));
        check("rst_amag",  32'(A_mag),     32'(0));
        check("rst_map",   32'(a_map),     32'(0));
`ifdef MUL_OPSTAGE_ZERO_FLAG_EN
        check("rst_zero",  32'(zero_o),    32'(0));
`endif

        // Table: each pair with out_ready=1 is valid for exactly one cycle.
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            out_ready = 1'b1;
            send_word(vecs[i].a);
            send_word(vecs[i].b);
            check_pair(tag, vecs[i].a_mag, vecs[i].b_mag, vecs[i].sa, vecs[i].sb, vecs[i].map);
`ifdef MUL_OPSTAGE_ZERO_FLAG_EN
            check({tag, "_zero"}, 32'(zero_o), 32'(vecs[i].zero));
`endif
            tick();
            check({tag, "_drop"}, 32'(out_valid), 32'(0));
        end

        // Hold with backpressure, then consume and capture new A in the same cycle.
        out_ready = 1'b0;
        send_word(16'h0011);
        send_word(16'hFFDE);
        in_valid = 1'b1;
        in_data  = 16'h0007;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("hold%0d_ready", c), 32'(in_ready), 32'(0));
            check_pair($sformatf("hold%0d", c), 16'h0011, 16'h0022, 1'b0, 1'b1, 16'h000F);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("cons_ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        #1;
        check("cons_valid", 32'(out_valid), 32'(0));
        check("cons_amag",  32'(A_mag),     32'(7));
        check("cons_ready2", 32'(in_ready), 32'(1));
        send_word(16'h0002);
        check_pair("cons_pair", 16'h0007, 16'h0002, 1'b0, 1'b0, 16'h0003);
        tick();

        // Flush in S_B blocks a same-cycle B; the next two words form the pair.
        send_word(16'h0005);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0009;
        #1;
        check("flush_ready", 32'(in_ready), 32'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_valid", 32'(out_valid), 32'(0));
        send_word(16'h0003);
        check("flush_noearly", 32'(out_valid), 32'(0));
        send_word(16'hFFFE);
        check_pair("flush_pair", 16'h0003, 16'h0002, 1'b0, 1'b1, 16'h0001);

        // Flush drops a held pair.
        out_ready = 1'b0;
        tick();
        check("hold_before_flush", 32'(out_valid), 32'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'(0));
        check("flush_out_ready", 32'(in_ready),  32'(1));

        // Reset while presenting a pair clears everything.
        send_word(16'hFFFD);
        send_word(16'h8000);
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst2_valid", 32'(out_valid), 32'(0));
        check("rst2_amag",  32'(A_mag),     32'(0));
        check("rst2_bmag",  32'(B_mag),     32'(0));
        check("rst2_map",   32'(a_map),     32'(0));
        check("rst2_sa",    32'(Sign_a),    32'(0));
        check("rst2_sb",    32'(Sign_b),    32'(0));
        check("rst2_ready", 32'(in_ready),  32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
